// File: rtl/mux16_arbiter_if.sv
// Handshake and bus bundle between two requesters, the arbiter and the downstream consumer.
interface mux16_arbiter_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid0;
  logic [DATA_W-1:0] in_data0;
  logic              in_ready0;
  logic              in_valid1;
  logic [DATA_W-1:0] in_data1;
  logic              in_ready1;
  logic              selector;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;

  // Environment side: requesters and consumer.
  modport master (
    output in_valid0, in_data0, in_valid1, in_data1, out_ready,
    input  in_ready0, in_ready1, selector, out_valid, out_data, busy
  );

  // Arbiter side.
  modport slave (
    input  in_valid0, in_data0, in_valid1, in_data1, out_ready,
    output in_ready0, in_ready1, selector, out_valid, out_data, busy
  );
endinterface

// File: rtl/mux16_arbiter.sv
// Round-robin arbiter for a 2:1 x DATA_W mux with bounded bursts and a one-entry output register.
module mux16_arbiter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux16_arbiter_if.slave     bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              last_owner_q, last_owner_d;
  logic              selector_q, selector_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              space;
  logic              rdy0, rdy1;
  logic              acc0, acc1;
  logic              burst_done;
  logic              own1;
  logic              own_valid;
  logic              oth_valid;
  state_e            other_state;

  // Handshake decode: the owner may push whenever the output register can take a word.
  always_comb begin
    space      = !out_valid_q || bus.out_ready;
    rdy0       = (state_q == OWN0) && space;
    rdy1       = (state_q == OWN1) && space;
    acc0       = bus.in_valid0 && rdy0;
    acc1       = bus.in_valid1 && rdy1;
    burst_done = (burst_cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST);
  end

  // Next-state: arbitration, burst accounting and the output register.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    own1         = (state_q == OWN1);
    own_valid    = own1 ? bus.in_valid1 : bus.in_valid0;
    oth_valid    = own1 ? bus.in_valid0 : bus.in_valid1;
    other_state  = own1 ? OWN0 : OWN1;

    if (acc0) begin
      out_data_d  = bus.in_data0;
      out_valid_d = 1'b1;
    end else if (acc1) begin
      out_data_d  = bus.in_data1;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (bus.in_valid0 && bus.in_valid1) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (bus.in_valid0) begin
          state_d = OWN0;
        end else if (bus.in_valid1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (acc0 || acc1) begin
          burst_cnt_d  = burst_cnt_q + CNT_W'(1);
          last_owner_d = own1;
          if (burst_done) begin
            burst_cnt_d = '0;
            if (oth_valid) state_d = other_state;
          end
        end else if (!own_valid) begin
          burst_cnt_d = '0;
          state_d     = oth_valid ? other_state : IDLE;
        end
        // Owner valid but output stalled: hold state and count.
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase

    selector_d = (state_d == OWN1);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_owner_q <= 1'b1;
      selector_q   <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      selector_q   <= selector_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign bus.in_ready0 = rdy0;
  assign bus.in_ready1 = rdy1;
  assign bus.selector  = selector_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_mux16_arbiter.sv
// Self-checking bench: cycle vectors for the directed scenarios, a data scoreboard, and a random soak.
module tb_mux16_arbiter;

  localparam int unsigned DATA_W = 16;

  typedef struct {
    logic              rst;
    logic              v0;
    logic [DATA_W-1:0] d0;
    logic              v1;
    logic [DATA_W-1:0] d1;
    logic              ordy;
    logic              chk;
    logic              r0;
    logic              r1;
    logic              sel;
    logic              ov;
    logic [DATA_W-1:0] od;
    logic              busy;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  vec_t vecs[$];
  logic [DATA_W-1:0] sbq[$];
  logic acc0_seen, acc1_seen;

  mux16_arbiter_if #(.DATA_W(DATA_W)) bus ();

  mux16_arbiter #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic rs, input logic v0, input logic [DATA_W-1:0] d0,
                     input logic v1, input logic [DATA_W-1:0] d1, input logic ordy,
                     input logic c, input logic r0, input logic r1, input logic sel,
                     input logic ov, input logic [DATA_W-1:0] od, input logic bsy);
    vec_t v;
    v.rst = rs; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
    v.chk = c; v.r0 = r0; v.r1 = r1; v.sel = sel; v.ov = ov; v.od = od; v.busy = bsy;
    vecs.push_back(v);
  endtask

  // Called at negedge: expected words enter on accept and leave on drain.
  task automatic sb_step();
    logic [DATA_W-1:0] e;
    if (rst) begin
      sbq.delete();
      acc0_seen = 1'b0;
      acc1_seen = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_word", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("sb_data", 32'(bus.out_data), 32'(e));
        end
      end
      acc0_seen = bus.in_valid0 && bus.in_ready0;
      acc1_seen = bus.in_valid1 && bus.in_ready1;
      if (acc0_seen) sbq.push_back(bus.in_data0);
      if (acc1_seen) sbq.push_back(bus.in_data1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    acc0_seen = 1'b0;
    acc1_seen = 1'b0;
    rst = 1'b1;
    bus.in_valid0 = 1'b0; bus.in_data0 = '0;
    bus.in_valid1 = 1'b0; bus.in_data1 = '0;
    bus.out_ready = 1'b1;

    //  rst v0 d0       v1 d1       ordy chk r0 r1 sel ov od       busy
    add(1, 0, 16'h0000, 0, 16'h0000, 1,  0,  0, 0, 0,  0, 16'h0000, 0); // r0 reset
    add(0, 1, 16'h0001, 0, 16'h0000, 1,  1,  0, 0, 0,  0, 16'h0000, 0); // r1 idle, arbitrate
    add(0, 1, 16'h0001, 0, 16'h0000, 1,  1,  1, 0, 0,  0, 16'h0000, 1); // r2 own0, ready
    for (int i = 0; i < 4; i++)
      add(0, 1, 16'h0001, 0, 16'h0000, 1, 1, 1, 0, 0, 1, 16'h0001, 1); // r3..r6 streaming, no yield
    add(1, 1, 16'h0001, 0, 16'h0000, 1,  1,  1, 0, 0,  1, 16'h0001, 1); // r7 reset mid-burst
    add(0, 1, 16'h0001, 1, 16'h0002, 1,  1,  0, 0, 0,  0, 16'h0000, 0); // r8 cleared, both valid
    add(0, 1, 16'h0001, 1, 16'h0002, 1,  1,  1, 0, 0,  0, 16'h0000, 1); // r9 req0 wins first
    for (int i = 0; i < 3; i++)
      add(0, 1, 16'h0001, 1, 16'h0002, 1, 1, 1, 0, 0, 1, 16'h0001, 1); // r10..r12
    add(0, 1, 16'h0001, 1, 16'h0002, 1,  1,  0, 1, 1,  1, 16'h0001, 1); // r13 switch, no gap
    for (int i = 0; i < 3; i++)
      add(0, 1, 16'h0001, 1, 16'h0002, 1, 1, 0, 1, 1, 1, 16'h0002, 1); // r14..r16
    add(0, 1, 16'h0001, 1, 16'h0002, 1,  1,  1, 0, 0,  1, 16'h0002, 1); // r17 back to req0
    add(0, 1, 16'h0001, 1, 16'h0002, 1,  1,  1, 0, 0,  1, 16'h0001, 1); // r18 beat 2
    add(0, 0, 16'h0001, 1, 16'h0002, 1,  1,  1, 0, 0,  1, 16'h0001, 1); // r19 owner drops
    add(0, 0, 16'h0001, 1, 16'h0002, 1,  1,  0, 1, 1,  0, 16'h0001, 1); // r20 direct yield
    for (int i = 0; i < 4; i++)
      add(0, 0, 16'h0001, 1, 16'h0002, 1, 1, 0, 1, 1, 1, 16'h0002, 1); // r21..r24 full burst, wrap
    vecs[$].v0 = 1'b1; vecs[$].d0 = 16'h0005; vecs[$].ordy = 1'b0; vecs[$].r1 = 1'b0; // r24 stall
    add(0, 1, 16'h0005, 1, 16'h0002, 0,  1,  0, 0, 1,  1, 16'h0002, 1); // r25 still stalled
    add(0, 1, 16'h0005, 1, 16'h0002, 1,  1,  0, 1, 1,  1, 16'h0002, 1); // r26 drain+accept
    add(0, 1, 16'h0005, 0, 16'h0000, 1,  1,  0, 1, 1,  1, 16'h0002, 1); // r27 ov stays 1
    add(0, 1, 16'h0005, 0, 16'h0000, 1,  1,  1, 0, 0,  0, 16'h0002, 1); // r28 own0
    add(0, 0, 16'h0000, 0, 16'h0000, 1,  1,  1, 0, 0,  1, 16'h0005, 1); // r29
    add(0, 0, 16'h0000, 0, 16'h0000, 1,  1,  0, 0, 0,  0, 16'h0005, 0); // r30 idle
    add(0, 0, 16'h0000, 1, 16'hBEEF, 1,  1,  0, 0, 0,  0, 16'h0005, 0); // r31 req1 only
    add(0, 0, 16'h0000, 1, 16'hBEEF, 1,  1,  0, 1, 1,  0, 16'h0005, 1); // r32 own1
    add(0, 0, 16'h0000, 0, 16'h0000, 1,  1,  0, 1, 1,  1, 16'hBEEF, 1); // r33 drop
    add(0, 0, 16'h0000, 0, 16'h0000, 1,  1,  0, 0, 0,  0, 16'hBEEF, 0); // r34 idle

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst           = vecs[i].rst;
      bus.in_valid0 = vecs[i].v0;
      bus.in_data0  = vecs[i].d0;
      bus.in_valid1 = vecs[i].v1;
      bus.in_data1  = vecs[i].d1;
      bus.out_ready = vecs[i].ordy;
      @(negedge clk);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_ready0", i),    32'(bus.in_ready0), 32'(vecs[i].r0));
        chk($sformatf("v%0d_ready1", i),    32'(bus.in_ready1), 32'(vecs[i].r1));
        chk($sformatf("v%0d_selector", i),  32'(bus.selector),  32'(vecs[i].sel));
        chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
        chk($sformatf("v%0d_out_data", i),  32'(bus.out_data),  32'(vecs[i].od));
        chk($sformatf("v%0d_busy", i),      32'(bus.busy),      32'(vecs[i].busy));
      end
      sb_step();
    end

    // Random soak: requesters hold their word until accepted; consumer stalls at random.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (!bus.in_valid0 || acc0_seen) begin
        bus.in_valid0 = ($urandom_range(0, 3) != 0);
        bus.in_data0  = DATA_W'($urandom);
      end
      if (!bus.in_valid1 || acc1_seen) begin
        bus.in_valid1 = ($urandom_range(0, 3) != 0);
        bus.in_data1  = DATA_W'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_ready0 && bus.in_ready1) chk("both_ready", 32'd1, 32'd0);
      if (bus.in_ready1 && !bus.selector) chk("ready1_sel", 32'(bus.selector), 32'd1);
      sb_step();
    end

    // Drain and confirm every accepted word came out.
    bus.in_valid0 = 1'b0;
    bus.in_valid1 = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid0 = 1'b0;
      bus.in_valid1 = 1'b0;
      @(negedge clk);
      sb_step();
    end
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_out_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux16_arbiter.md
Name: mux16_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 2:1 x 16-bit datapath mux.
- Two requesters offer 16-bit words over valid/ready; the block owns the mux selector and grants one requester at a time.
- Accepted words land in a one-entry registered output stage (valid/ready) feeding the downstream consumer, e.g. a register-file write port or bus.
- Burst length per grant is bounded for fairness.

Parameters:
- DATA_W, 16, width of each requester word and of the output.
- MAX_BURST, 4, maximum accepted beats per grant before yielding to a waiting requester (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid0  input  1  requester 0 has a word.
- in_data0  input  DATA_W  requester 0 word (mux_input0).
- in_ready0  output  1  requester 0 word accepted this cycle when in_valid0 is also high.
- in_valid1  input  1  requester 1 has a word.
- in_data1  input  DATA_W  requester 1 word (mux_input1).
- in_ready1  output  1  requester 1 word accepted this cycle when in_valid1 is also high.
- selector  output  1  mux select; 1 selects requester 1.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  registered mux output.
- out_ready  input  1  consumer takes the word when out_valid is also high.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, selector=0, out_valid=0, out_data=0, burst_cnt=0, last_owner=1 (so requester 0 wins the first tie).
  - Reset overrides everything, including mid-burst. A pending out word is discarded.
- States: IDLE, OWN0, OWN1.
  - selector = 1 only in OWN1; otherwise 0.
  - busy = (state != IDLE).
- Output stage:
  - space = !out_valid || out_ready.
  - in_readyX = (state == OWNX) && space. The ready of the non-owner is always 0. in_readyX is combinational from state, out_valid and out_ready.
  - On accept (in_validX && in_readyX): out_data <= in_dataX and out_valid <= 1 at the next edge.
  - If out_valid && out_ready with no accept: out_valid <= 0 at the next edge, and out_data holds its value.
  - Simultaneous drain and accept: out_data is replaced and out_valid stays 1. Full throughput is 1 word/cycle.
- IDLE:
  - No inputs are accepted.
  - If exactly one in_valid is high, go to OWN of that requester.
  - If both are high, go to OWN of !last_owner.
  - Set burst_cnt=0. Arbitration costs 1 cycle.
- OWNX:
  - On accept: burst_cnt++, last_owner <= X.
  - If the accept makes burst_cnt == MAX_BURST:
    - Other requester valid this cycle: go to OWN(other), burst_cnt=0.
    - Otherwise: stay in OWNX with burst_cnt=0.
  - If in_validX=0: yield to OWN(other) if the other is valid, else go to IDLE; burst_cnt=0.
    - A direct switch costs no IDLE cycle.
  - If in_validX=1 and not ready (output stalled): stay in OWNX and hold burst_cnt. No switching while stalled.
- Latency:
  - Request from IDLE → in_ready at cycle +1 (if space) → out_valid at cycle +2.
- Words are never duplicated or dropped.
  - Each accepted word appears exactly once on out_data, in accept order.
  - Requesters must hold in_dataX stable while in_validX && !in_readyX.

Test Plan:
1. Reset, then in_valid0=1 with in_data0=0x0001 held, in_valid1=0, out_ready=1:
   - cycle 1: state OWN0, selector=0.
   - cycle 1: in_ready0=1.
   - cycle 2: out_valid=1, out_data=0x0001.
   - Then 0x0001 streams 1/cycle with no yield (burst_cnt wraps and state stays OWN0).
2. Both valid from IDLE after reset (data0=0x0001, data1=0x0002), out_ready=1, MAX_BURST=4:
   - Four 0x0001 beats, then selector=1 with no gap.
   - Four 0x0002 beats, then back to requester 0.
   - Output sequence: 1,1,1,1,2,2,2,2,1…
3. Owner 0 drops in_valid0 after 2 beats while in_valid1=1:
   - Next cycle state=OWN1, selector=1, in_ready1=1.
   - burst_cnt restarts, so requester 1 gets a full 4 beats.
4. Back-pressure: out_ready=0 with out_valid=1:
   - in_ready0=0, out_data is held, state stays OWN0 even though in_valid1=1.
   - Raising out_ready gives drain+accept in the same cycle, and out_valid stays 1.
5. Assert rst mid-burst with out_valid=1:
   - Next cycle out_valid=0, out_data=0, selector=0, busy=0.
   - With both valid afterwards, requester 0 is granted first.
6. Single requester 1 only (data1=0xBEEF):
   - selector=1 at cycle +1, out_data=0xBEEF at cycle +2.
   - Dropping in_valid1 gives IDLE and busy=0 the next cycle.
